ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/mem_pkg.sv | 16 +
 rtl/access_timer.sv | 28 ++
 rtl/ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the instruction/data RAM arbiter: the arbiter FSM states
// and the class of requester that was served most recently.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2
    } state_e;

    typedef enum logic {
        SERVED_DATA  = 1'b0,
        SERVED_INSTR = 1'b1
    } served_e;

endpackage

// File: rtl/access_timer.sv
// Per-access wait counter; expired_o rises on the last cycle an access may
// spend waiting for the RAM before the arbiter gives up on it.
module access_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [W-1:0] count_q;

    assign expired_o = (count_q == W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && !expired_o) begin
            count_q <= count_q + W'(1);
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving instruction fetches and data accesses turns at a
// single-ported RAM, with one access in flight and a per-access timeout.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iren,
    input  logic [31:0] imemaddr,
    input  logic        dren,
    input  logic        dwen,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        ramREN,
    output logic        ramWEN,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] imemload,
    output logic [31:0] dmemload,
    output logic        err
);
    state_e      state_q, state_d;
    served_e     last_q, last_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        write_q, write_d;
    logic        ihit_q, ihit_d;
    logic        dhit_q, dhit_d;
    logic [31:0] imem_q, imem_d;
    logic [31:0] dmem_q, dmem_d;
    logic        err_q, err_d;

    logic dataPend, instrPend, grantData, grantInstr, expired;

    // A requester whose hit is pulsing still holds its request; mask it so it is not served twice.
    assign dataPend   = (dren | dwen) & ~dhit_q;
    assign instrPend  = iren & ~ihit_q;
    assign grantData  = dataPend & (~instrPend | (last_q == SERVED_INSTR));
    assign grantInstr = instrPend & ~grantData;

    access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .clear_i  (state_q == IDLE),
        .enable_i ((state_q != IDLE) && !ram_ready),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        store_d = store_q;
        write_d = write_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;
        imem_d  = imem_q;
        dmem_d  = dmem_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (grantData) begin
                    state_d = DATA;
                    addr_d  = dmemaddr;
                    store_d = dmemstore;
                    write_d = dwen;
                end else if (grantInstr) begin
                    state_d = INSTR;
                    addr_d  = imemaddr;
                    store_d = '0;
                    write_d = 1'b0;
                end
            end
            DATA: begin
                if (ram_ready) begin
                    dhit_d  = 1'b1;
                    dmem_d  = write_q ? dmem_q : ramload;
                    state_d = IDLE;
                    last_d  = SERVED_DATA;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    last_d  = SERVED_DATA;
                end
            end
            INSTR: begin
                if (ram_ready) begin
                    ihit_d  = 1'b1;
                    imem_d  = ramload;
                    state_d = IDLE;
                    last_d  = SERVED_INSTR;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    last_d  = SERVED_INSTR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset starts with instruction marked as last served so data wins the first contention.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= SERVED_INSTR;
            addr_q  <= '0;
            store_q <= '0;
            write_q <= 1'b0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            imem_q  <= '0;
            dmem_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            write_q <= write_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            imem_q  <= imem_d;
            dmem_q  <= dmem_d;
            err_q   <= err_d;
        end
    end

    assign ramREN   = (state_q == INSTR) | ((state_q == DATA) & ~write_q);
    assign ramWEN   = (state_q == DATA) & write_q;
    assign ramaddr  = (state_q == IDLE) ? 32'h0 : addr_q;
    assign ramstore = (state_q == DATA) ? store_q : 32'h0;
    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign imemload = imem_q;
    assign dmemload = dmem_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a RAM model answers reads with address^KEY,
// and every expected hit is queued when its request is driven.
module tb_ram_arbiter;
    localparam logic [31:0] KEY = 32'hB9F9B9F9;

    typedef struct {
        logic        isData;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iren, dren, dwen;
    logic [31:0] imemaddr, dmemaddr, dmemstore;
    logic [31:0] ramload, ramaddr, ramstore;
    logic        ram_ready, ramREN, ramWEN;
    logic        ihit, dhit, err;
    logic [31:0] imemload, dmemload;

    logic        readyAuto, readyForce;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        monEntry;
    logic [31:0] expDmem;
    int          cnt;

    ram_arbiter #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iren(iren), .imemaddr(imemaddr),
        .dren(dren), .dwen(dwen), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .ramload(ramload), .ram_ready(ram_ready),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
        .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
        .err(err)
    );

    always #5 CLK = ~CLK;

    assign ramload   = ramaddr ^ KEY;
    assign ram_ready = readyForce | (readyAuto & (ramREN | ramWEN));

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && (ihit || dhit)) begin
            if (sb.size() == 0) begin
                check32("unexpectedHit", {30'b0, dhit, ihit}, 32'h0);
            end else begin
                monEntry = sb.pop_front();
                check32("hitIsData", {31'b0, dhit}, {31'b0, monEntry.isData});
                check32("hitIsInstr", {31'b0, ihit}, {31'b0, ~monEntry.isData});
                if (monEntry.isData) check32("dmemload", dmemload, monEntry.data);
                else                 check32("imemload", imemload, monEntry.data);
            end
        end
    end

    task automatic applyReset();
        RST = 1'b1;
        iren = 0; dren = 0; dwen = 0;
        imemaddr = '0; dmemaddr = '0; dmemstore = '0;
        readyAuto = 1'b1; readyForce = 1'b0;
        sb.delete();
        expDmem = '0;
        repeat (2) @(negedge CLK);
        check32("rstOutputs", {26'b0, ramREN, ramWEN, ihit, dhit, err, 1'b0}, 32'h0);
        check32("rstRamaddr", ramaddr, 32'h0);
        check32("rstImemload", imemload, 32'h0);
        check32("rstDmemload", dmemload, 32'h0);
        RST = 1'b0;
    endtask

    task automatic runUntilDone(input int bound, input string tag);
        int n = 0;
        while ((iren | dren | dwen) && n < bound) begin
            @(negedge CLK);
            if (dhit) begin dren = 0; dwen = 0; end
            if (ihit) iren = 0;
            n++;
        end
        check32({tag, "_done"}, {31'b0, iren | dren | dwen}, 32'h0);
        #1;
        check32({tag, "_queue"}, 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyReset();

        // Single fetch with minimum latency
        @(negedge CLK);
        iren = 1; imemaddr = 32'hABCDABCD;
        sb.push_back('{1'b0, 32'h12341234});
        @(negedge CLK);
        check32("fetchREN", {30'b0, ramREN, ramWEN}, 32'h2);
        check32("fetchAddr", ramaddr, 32'hABCDABCD);
        check32("fetchNoEarlyHit", {31'b0, ihit}, 32'h0);
        @(negedge CLK);
        check32("fetchHit", {31'b0, ihit}, 32'h1);
        check32("fetchData", imemload, 32'h12341234);
        iren = 0;
        @(negedge CLK);
        check32("fetchPulse", {30'b0, ihit, ramREN}, 32'h0);

        // Simultaneous fetch and load after reset: data first
        applyReset();
        @(negedge CLK);
        iren = 1; imemaddr = 32'h00001111;
        dren = 1; dmemaddr = 32'h56785678;
        expDmem = 32'h56785678 ^ KEY;
        sb.push_back('{1'b1, expDmem});
        sb.push_back('{1'b0, 32'h00001111 ^ KEY});
        runUntilDone(20, "contend");

        // Store leaves dmemload alone
        @(negedge CLK);
        dwen = 1; dmemaddr = 32'hABCDABCD; dmemstore = 32'h33333333;
        sb.push_back('{1'b1, expDmem});
        @(negedge CLK);
        check32("storeEn", {30'b0, ramREN, ramWEN}, 32'h1);
        check32("storeData", ramstore, 32'h33333333);
        check32("storeAddr", ramaddr, 32'hABCDABCD);
        runUntilDone(20, "store");
        check32("storeDmem", dmemload, expDmem);

        // ram_ready while idle has no effect
        readyForce = 1;
        repeat (3) @(negedge CLK);
        check32("idleReady", {29'b0, ihit, dhit, ramREN}, 32'h0);
        check32("idleDmem", dmemload, expDmem);
        readyForce = 0;

        // Both held continuously: strict alternation D,I,D,I,D,I
        applyReset();
        @(negedge CLK);
        iren = 1; imemaddr = 32'h00002222;
        dren = 1; dmemaddr = 32'h00004444;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{1'b1, 32'h00004444 ^ KEY});
            sb.push_back('{1'b0, 32'h00002222 ^ KEY});
        end
        cnt = 0;
        for (int k = 0; k < 40 && cnt < 6; k++) begin
            @(negedge CLK);
            if (ihit || dhit) cnt++;
        end
        iren = 0; dren = 0;
        check32("rrHits", 32'(cnt), 32'd6);
        #1;
        check32("rrQueue", 32'(sb.size()), 32'h0);
        @(negedge CLK);
        check32("rrNoExtra", {30'b0, ramREN, ramWEN}, 32'h0);
        expDmem = 32'h00004444 ^ KEY;

        // Timeout with RAM never ready
        readyAuto = 0;
        @(negedge CLK);
        iren = 1; imemaddr = 32'h00003333;
        @(negedge CLK);
        cnt = 0;
        while (ramREN && cnt < 20) begin
            cnt++;
            @(negedge CLK);
        end
        iren = 0;
        check32("toCycles", 32'(cnt), 32'd4);
        check32("toErr", {30'b0, err, ihit}, 32'h2);
        readyAuto = 1;
        @(negedge CLK);
        dren = 1; dmemaddr = 32'h00005555;
        sb.push_back('{1'b1, 32'h00005555 ^ KEY});
        runUntilDone(20, "afterTo");
        check32("errSticky", {31'b0, err}, 32'h1);
        applyReset();
        check32("errCleared", {31'b0, err}, 32'h0);

        // Reset in the middle of a fetch
        readyAuto = 0;
        @(negedge CLK);
        iren = 1; imemaddr = 32'h00007777;
        @(negedge CLK);
        check32("preRstREN", {31'b0, ramREN}, 32'h1);
        #2 RST = 1;
        #1;
        check32("midRstCtl", {27'b0, ramREN, ramWEN, ihit, dhit, err}, 32'h0);
        check32("midRstAddr", ramaddr, 32'h0);
        check32("midRstLoads", imemload | dmemload | ramstore, 32'h0);
        iren = 0;
        repeat (2) @(negedge CLK);
        RST = 0;
        readyAuto = 1;
        repeat (2) @(negedge CLK);
        check32("postRst", {30'b0, ihit, ramREN}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
